// File: rtl/bird_io_bridge.sv
// bird_io_bridge: memory-bus bridge for the bird CPU.
// Steers CPU accesses to external RAM or to a 4-word I/O window that holds
// a FIFO-buffered UART transmitter and a single-entry receive holding register.
// Optional macro BIRD_IO_TIMER_EN adds a loadable 16-bit free-running timer
// at IO_BASE+3.
module bird_io_bridge #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] IO_BASE      = 16'h0FF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  input  logic        memwt,
  output logic [15:0] data_in,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  input  logic        ext_valid,
  input  logic [7:0]  ext_data,
  output logic        ext_ready,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  // Bus decode
  logic       io_sel, io_wr;
  logic [1:0] io_off;
  assign io_sel = (address[15:2] == IO_BASE[15:2]);
  assign io_off = address[1:0];
  assign io_wr  = memwt & io_sel;
  assign ram_we = memwt & ~io_sel;

  // TX FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_full, tx_empty, push, pop;

  // TX serializer state
  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          baud_last;

  // RX holding register
  logic       rx_valid_q;
  logic [7:0] rx_byte_q;

  logic [15:0] timer_rd;

  assign tx_full   = (count_q == CW'(FIFO_DEPTH));
  assign tx_empty  = (count_q == '0);
  // Full FIFO drops the push even if a pop happens on the same edge
  assign push      = io_wr & (io_off == 2'd0) & ~tx_full;
  assign pop       = (state_q == IDLE) & ~tx_empty;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // FIFO pointer/count/overflow next state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (io_wr && io_off == 2'd0 && tx_full) ovf_d = 1'b1;
    else if (io_wr && io_off == 2'd1)       ovf_d = 1'b0;
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care until written so no reset
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wptr_q] <= data_out[7:0];
  end

  // UART TX FSM; uart_tx is registered from the current state, so it lags
  // the state by one cycle and every bit still lasts CLKS_PER_BIT cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (!tx_empty) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= DATA;
          end else baud_q <= baud_q + BW'(1);
        end
        DATA: begin
          tx_q <= shift_q[0];
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else baud_q <= baud_q + BW'(1);
        end
        default: begin
          tx_q <= 1'b1;
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else baud_q <= baud_q + BW'(1);
        end
      endcase
    end
  end

  // RX capture; a capture and an ack cannot coincide since ready is low when full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else if (ext_valid && !rx_valid_q) begin
      rx_valid_q <= 1'b1;
      rx_byte_q  <= ext_data;
    end else if (io_wr && io_off == 2'd2) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign ext_ready = ~rx_valid_q;
  assign uart_tx   = tx_q;

`ifdef BIRD_IO_TIMER_EN
  logic [15:0] timer_q;
  // Free-running timer; a write loads instead of incrementing on that edge
  always_ff @(posedge clk) begin
    if (!rst_n)                        timer_q <= '0;
    else if (io_wr && io_off == 2'd3)  timer_q <= data_out;
    else                               timer_q <= timer_q + 16'd1;
  end
  assign timer_rd = timer_q;
`else
  logic unused_data_hi;
  assign unused_data_hi = ^data_out[15:8];
  assign timer_rd       = '0;
`endif

  // Combinational read mux, no read side effects
  always_comb begin
    data_in = ram_rdata;
    if (io_sel) begin
      case (io_off)
        2'd0:    data_in = '0;
        2'd1:    data_in = {12'h000, ovf_q, rx_valid_q, tx_empty, tx_full};
        2'd2:    data_in = {8'h00, rx_byte_q};
        default: data_in = timer_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_io_bridge.sv
// Directed self-checking bench for bird_io_bridge (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_bird_io_bridge;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address = '0, data_out = '0, ram_rdata = '0;
  logic        memwt = 1'b0, ext_valid = 1'b0;
  logic [7:0]  ext_data = '0;
  logic [15:0] data_in;
  logic        ram_we, ext_ready, uart_tx;

  int errors = 0;
  int checks = 0;
  logic [7:0] rxq[$];

  bird_io_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .IO_BASE(16'h0FF0)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_out(data_out),
    .memwt(memwt), .data_in(data_in), .ram_rdata(ram_rdata), .ram_we(ram_we),
    .ext_valid(ext_valid), .ext_data(ext_data), .ext_ready(ext_ready),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(tag, data_in, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address  = a;
    data_out = d;
    memwt    = 1'b1;
    tick();
    memwt    = 1'b0;
  endtask

  // Serial monitor: decodes 8N1 frames at CPB clocks/bit, sampling mid-bit
  initial begin : mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        repeat (CPB + 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = uart_tx;
          repeat (CPB) @(negedge clk);
        end
        if (uart_tx === 1'b1) rxq.push_back(b);
      end
    end
  end

  initial begin
    logic [9:0] fr;
    int n, lowcnt;

    // Reset state
    tick(); tick();
    chk("rst_tx", 16'(uart_tx), 16'h0001);
    chk("rst_ready", 16'(ext_ready), 16'h0001);
    chk_rd("rst_status", 16'h0FF1, 16'h0002);
    chk_rd("rst_rxdata", 16'h0FF2, 16'h0000);
    rst_n = 1'b1;
    tick();

    // RAM pass-through and decode boundaries (no clock edge while memwt is high)
    data_out = 16'h1234;
    memwt = 1'b1;
    address = 16'h0010; #1 chk("we_ram", 16'(ram_we), 16'h0001);
    address = 16'h0FF0; #1 chk("we_io0", 16'(ram_we), 16'h0000);
    address = 16'h0FF3; #1 chk("we_io3", 16'(ram_we), 16'h0000);
    address = 16'h0FEF; #1 chk("we_below", 16'(ram_we), 16'h0001);
    address = 16'h0FF4; #1 chk("we_above", 16'(ram_we), 16'h0001);
    memwt = 1'b0;
    #1 chk("we_idle", 16'(ram_we), 16'h0000);
    tick();
    ram_rdata = 16'hBEEF;
    chk_rd("rd_ram", 16'h0020, 16'hBEEF);
    chk_rd("rd_above", 16'h0FF4, 16'hBEEF);
    chk_rd("rd_io0", 16'h0FF0, 16'h0000);

    // Timer / unused word at IO_BASE+3
`ifdef BIRD_IO_TIMER_EN
    wr(16'h0FF3, 16'hFFFE);
    chk_rd("tmr_load", 16'h0FF3, 16'hFFFE);
    tick(); chk("tmr_inc", data_in, 16'hFFFF);
    tick(); chk("tmr_wrap", data_in, 16'h0000);
`else
    wr(16'h0FF3, 16'hFFFE);
    chk_rd("io3_zero", 16'h0FF3, 16'h0000);
`endif

    // Single frame, exact timing
    rxq.delete();
    wr(16'h0FF0, 16'h0055);
    chk("t2_e0", 16'(uart_tx), 16'h0001);
    tick(); chk("t2_e1", 16'(uart_tx), 16'h0001);
    tick();
    fr = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      chk($sformatf("t2_bit%0d", i), 16'(uart_tx), 16'(fr[i / CPB]));
      tick();
    end
    chk("t2_idle", 16'(uart_tx), 16'h0001);
    chk("t2_nbytes", 16'(rxq.size()), 16'h0001);
    if (rxq.size() > 0) chk("t2_byte", 16'(rxq[0]), 16'h0055);
    chk_rd("t2_status", 16'h0FF1, 16'h0002);

    // FIFO full and overflow
    rxq.delete();
    address = 16'h0FF0;
    for (int i = 0; i < 10; i++) begin
      data_out = 16'(8'h10 + i);
      memwt = 1'b1;
      tick();
    end
    memwt = 1'b0;
    chk_rd("t3_full_ovf", 16'h0FF1, 16'h0009);
    wr(16'h0FF1, 16'hFFFF);
    chk_rd("t3_ovf_clr", 16'h0FF1, 16'h0001);
    n = 0;
    while (rxq.size() < 9 && n < 2000) begin
      tick();
      n++;
    end
    repeat (60) tick();
    chk("t3_nbytes", 16'(rxq.size()), 16'h0009);
    for (int i = 0; i < 9; i++)
      if (i < rxq.size()) chk($sformatf("t3_byte%0d", i), 16'(rxq[i]), 16'(8'h10 + i));
    chk_rd("t3_status", 16'h0FF1, 16'h0002);

    // RX handshake
    ext_data = 8'hA7;
    ext_valid = 1'b1;
    #1 chk("t4_ready0", 16'(ext_ready), 16'h0001);
    tick();
    chk_rd("t4_status", 16'h0FF1, 16'h0006);
    chk_rd("t4_rxdata", 16'h0FF2, 16'h00A7);
    chk("t4_notready", 16'(ext_ready), 16'h0000);
    ext_data = 8'h3C;
    tick(); tick();
    chk_rd("t4_held", 16'h0FF2, 16'h00A7);
    wr(16'h0FF2, 16'h0000);
    chk("t4_ready_ack", 16'(ext_ready), 16'h0001);
    chk_rd("t4_status_ack", 16'h0FF1, 16'h0002);
    chk_rd("t4_byte_kept", 16'h0FF2, 16'h00A7);
    tick();
    chk("t4_ready_cap2", 16'(ext_ready), 16'h0000);
    chk_rd("t4_rxdata2", 16'h0FF2, 16'h003C);
    ext_valid = 1'b0;

    // Reset mid-frame with bytes queued and rx_valid set
    address = 16'h0FF0;
    for (int i = 0; i < 4; i++) begin
      data_out = 16'(8'h81 + i);
      memwt = 1'b1;
      tick();
    end
    memwt = 1'b0;
    repeat (12) tick();
    chk_rd("t5_queued", 16'h0FF1, 16'h0004);
    rst_n = 1'b0;
    tick();
    chk("t5_tx_rst", 16'(uart_tx), 16'h0001);
    wr(16'h0FF0, 16'h0099);
    chk_rd("t5_status", 16'h0FF1, 16'h0002);
    chk_rd("t5_rxdata", 16'h0FF2, 16'h0000);
    chk("t5_ready", 16'(ext_ready), 16'h0001);
    rst_n = 1'b1;
    repeat (50) tick();
    rxq.delete();
    lowcnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (uart_tx !== 1'b1) lowcnt++;
      tick();
    end
    chk("t5_no_tx", 16'(lowcnt), 16'h0000);
    chk("t5_no_frames", 16'(rxq.size()), 16'h0000);
    chk_rd("t5_status_end", 16'h0FF1, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
